// File: rtl/gemm_cmd_loader.sv
// gemm_cmd_loader
//   System-bus initiator that replays a list of (target address, data)
//   descriptor pairs held in data memory as writes into the GEMM
//   configuration window. Every fetch and every write is a single bus
//   transaction, accepted in a cycle where system_bus_en && bus_gnt.
//
// Ports
//   clk, rst             system clock, asynchronous active-high reset
//   start                one-cycle pulse, honoured only when idle
//   list_base            byte address of the first descriptor (bits [1:0] ignored)
//   list_count           number of descriptor pairs (0 completes immediately)
//   busy, done, error    run status; error is sticky until the next accepted start
//   err_addr             offending target address while error is high
//   bus_gnt              arbiter grant
//   system_bus_*         request, direction, address, write data, byte mask
//   system_bus_rd_data   read data, valid the cycle after an accepted read
//
// state | meaning
// IDLE  | waiting for start
// RD_A  | requesting read of the descriptor target address
// WT_A  | capturing target address, checking it lies in the GEMM window
// RD_D  | requesting read of the descriptor data word
// WT_D  | capturing data word
// WR    | requesting write of data word to the target address
// FIN   | done pulse
// ERR   | error raised, no write issued for the bad descriptor

module gemm_cmd_loader #(
    parameter int          MAX_CNT_W   = 16,
    parameter logic [3:0]  GEMM_REGION = 4'b1001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          list_base,
    input  logic [MAX_CNT_W-1:0] list_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          err_addr,
    input  logic                 bus_gnt,
    output logic                 system_bus_en,
    output logic                 system_bus_rdwr,
    output logic [31:0]          system_bus_addr,
    output logic [31:0]          system_bus_wr_data,
    output logic [3:0]           system_bus_mask,
    input  logic [31:0]          system_bus_rd_data
);

    typedef enum logic [2:0] {
        IDLE, RD_A, WT_A, RD_D, WT_D, WR, FIN, ERR
    } state_t;

    state_t               state;
    logic [31:0]          ptr;
    logic [31:0]          tgt;
    logic [MAX_CNT_W-1:0] remaining;

    // All bus outputs are registered and loaded on the transition into a
    // request state, so they are naturally held while the grant is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            ptr                <= '0;
            tgt                <= '0;
            remaining          <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            err_addr           <= '0;
            system_bus_en      <= 1'b0;
            system_bus_rdwr    <= 1'b0;
            system_bus_addr    <= '0;
            system_bus_wr_data <= '0;
            system_bus_mask    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        err_addr <= '0;
                        if (list_count != '0) begin
                            ptr             <= list_base & 32'hFFFF_FFFC;
                            remaining       <= list_count;
                            busy            <= 1'b1;
                            system_bus_en   <= 1'b1;
                            system_bus_rdwr <= 1'b0;
                            system_bus_addr <= list_base & 32'hFFFF_FFFC;
                            system_bus_mask <= 4'hF;
                            state           <= RD_A;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                RD_A: begin
                    if (bus_gnt) begin
                        ptr             <= ptr + 32'd4;
                        system_bus_en   <= 1'b0;
                        system_bus_addr <= '0;
                        system_bus_mask <= '0;
                        state           <= WT_A;
                    end
                end

                WT_A: begin
                    tgt <= system_bus_rd_data;
                    if (system_bus_rd_data[31:28] != GEMM_REGION) begin
                        err_addr <= system_bus_rd_data;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ERR;
                    end else begin
                        system_bus_en   <= 1'b1;
                        system_bus_rdwr <= 1'b0;
                        system_bus_addr <= ptr;
                        system_bus_mask <= 4'hF;
                        state           <= RD_D;
                    end
                end

                RD_D: begin
                    if (bus_gnt) begin
                        ptr             <= ptr + 32'd4;
                        system_bus_en   <= 1'b0;
                        system_bus_addr <= '0;
                        system_bus_mask <= '0;
                        state           <= WT_D;
                    end
                end

                WT_D: begin
                    system_bus_wr_data <= system_bus_rd_data;
                    system_bus_en      <= 1'b1;
                    system_bus_rdwr    <= 1'b1;
                    system_bus_addr    <= tgt & 32'hFFFF_FFFC;
                    system_bus_mask    <= 4'hF;
                    state              <= WR;
                end

                WR: begin
                    if (bus_gnt) begin
                        remaining          <= remaining - 1'b1;
                        system_bus_rdwr    <= 1'b0;
                        system_bus_wr_data <= '0;
                        if (remaining == {{(MAX_CNT_W-1){1'b0}}, 1'b1}) begin
                            system_bus_en   <= 1'b0;
                            system_bus_addr <= '0;
                            system_bus_mask <= '0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            state           <= FIN;
                        end else begin
                            // Next descriptor fetch is issued back-to-back.
                            system_bus_en   <= 1'b1;
                            system_bus_addr <= ptr;
                            system_bus_mask <= 4'hF;
                            state           <= RD_A;
                        end
                    end
                end

                FIN:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
